// File: rtl/output_port_arbiter_pkg.sv
// Shared constants and helpers for the router output-port scheduler.
// The hop field is a down-counter that stops at zero instead of wrapping.
package output_port_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int HOP_MSB        = 55;
    localparam int HOP_LSB        = 48;
    localparam logic [7:0] PE_HOP = 8'h00;

    typedef enum logic {
        VC_EVEN = 1'b0,
        VC_ODD  = 1'b1
    } vc_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] hop_dec(input logic [7:0] hop);
        return (hop == PE_HOP) ? PE_HOP : hop - 8'd1;
    endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant and link signals of one router output port.
// master = upstream inputs plus downstream ready; slave = the arbiter.
interface output_port_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 64
);
    logic                          polarity;
    logic [N_REQ-1:0]              req_even;
    logic [N_REQ-1:0]              req_odd;
    logic [N_REQ*DATA_WIDTH-1:0]   din_even;
    logic [N_REQ*DATA_WIDTH-1:0]   din_odd;
    logic [N_REQ-1:0]              gnt_even;
    logic [N_REQ-1:0]              gnt_odd;
    logic                          so;
    logic                          ri;
    logic [DATA_WIDTH-1:0]         dout;

    modport master (
        output polarity, req_even, req_odd, din_even, din_odd, ri,
        input  gnt_even, gnt_odd, so, dout
    );

    modport slave (
        input  polarity, req_even, req_odd, din_even, din_odd, ri,
        output gnt_even, gnt_odd, so, dout
    );
endinterface

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces a one-hot grant and the winner index for the pointer update.
module rr_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] winner
);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = IW'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Output-port scheduler: per-VC round-robin into one-flit buffers, link driven
// by the VC opposite to the one arbitrating in the current polarity phase.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_REQ      = 2,
    parameter int HOP_UPDATE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output_port_arbiter_if.slave  bus
);

    localparam int IW = idx_width(N_REQ);

    logic                  arb_en_even, arb_en_odd;
    logic [N_REQ-1:0]      req_en_even, req_en_odd;
    logic [N_REQ-1:0]      gnt_even, gnt_odd;
    logic [IW-1:0]         win_even, win_odd;
    logic [IW-1:0]         ptr_even, ptr_odd;
    logic                  full_even, full_odd;
    logic [DATA_WIDTH-1:0] buf_even, buf_odd;
    logic [DATA_WIDTH-1:0] cap_even, cap_odd;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  so_q;

    function automatic logic [DATA_WIDTH-1:0] capture(
        input logic [N_REQ-1:0]            gnt,
        input logic [N_REQ*DATA_WIDTH-1:0] din
    );
        logic [DATA_WIDTH-1:0] flit;
        flit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) flit = din[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (HOP_UPDATE != 0) flit[HOP_MSB:HOP_LSB] = hop_dec(flit[HOP_MSB:HOP_LSB]);
        return flit;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
        return (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
    endfunction

    // A full buffer blocks its own grants so no captured flit is overwritten.
    assign arb_en_even = !rst && !bus.polarity && !full_even;
    assign arb_en_odd  = !rst &&  bus.polarity && !full_odd;
    assign req_en_even = bus.req_even & {N_REQ{arb_en_even}};
    assign req_en_odd  = bus.req_odd  & {N_REQ{arb_en_odd}};

    rr_arbiter #(.N(N_REQ)) u_arb_even (
        .req    (req_en_even),
        .ptr    (ptr_even),
        .gnt    (gnt_even),
        .winner (win_even)
    );

    rr_arbiter #(.N(N_REQ)) u_arb_odd (
        .req    (req_en_odd),
        .ptr    (ptr_odd),
        .gnt    (gnt_odd),
        .winner (win_odd)
    );

    assign cap_even = capture(gnt_even, bus.din_even);
    assign cap_odd  = capture(gnt_odd,  bus.din_odd);

    assign bus.gnt_even = gnt_even;
    assign bus.gnt_odd  = gnt_odd;
    assign bus.so       = so_q;
    assign bus.dout     = dout_q;

    // Capture and transmit of one VC live in opposite phases, so their
    // updates to the same full flag can never land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            so_q      <= 1'b0;
            dout_q    <= '0;
            full_even <= 1'b0;
            full_odd  <= 1'b0;
            ptr_even  <= '0;
            ptr_odd   <= '0;
            buf_even  <= '0;
            buf_odd   <= '0;
        end else begin
            so_q <= 1'b0;
            if (|gnt_even) begin
                buf_even  <= cap_even;
                full_even <= 1'b1;
                ptr_even  <= next_ptr(win_even);
            end
            if (|gnt_odd) begin
                buf_odd  <= cap_odd;
                full_odd <= 1'b1;
                ptr_odd  <= next_ptr(win_odd);
            end
            if (!bus.polarity && full_odd && bus.ri) begin
                so_q     <= 1'b1;
                dout_q   <= buf_odd;
                full_odd <= 1'b0;
            end
            if (bus.polarity && full_even && bus.ri) begin
                so_q      <= 1'b1;
                dout_q    <= buf_even;
                full_even <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus random traffic,
// two DUTs (hop update on/off) checked against a flit-level reference model.
module tb_output_port_arbiter;

    localparam int N  = 2;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            pol;
    logic [N-1:0]    re, ro;
    logic [N*DW-1:0] de, dod;
    logic            ri;

    output_port_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus1 ();
    output_port_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus0 ();

    assign bus1.polarity = pol;  assign bus0.polarity = pol;
    assign bus1.req_even = re;   assign bus0.req_even = re;
    assign bus1.req_odd  = ro;   assign bus0.req_odd  = ro;
    assign bus1.din_even = de;   assign bus0.din_even = de;
    assign bus1.din_odd  = dod;  assign bus0.din_odd  = dod;
    assign bus1.ri       = ri;   assign bus0.ri       = ri;

    output_port_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .HOP_UPDATE(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );
    output_port_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .HOP_UPDATE(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );

    // reference model: index 0 = even VC, 1 = odd VC
    bit          m_full [2];
    int          m_ptr  [2];
    logic [63:0] m_buf1 [2];
    logic [63:0] m_buf0 [2];
    logic        m_so;
    logic [63:0] m_dout1, m_dout0;

    logic [1:0]  obs_ge, obs_go;
    logic        obs_so;
    logic [63:0] obs_dout1, obs_dout0;
    logic [1:0]  rr_seq [4];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hop_model(input logic [63:0] d);
        logic [63:0] r;
        int h;
        r = d;
        h = int'(d[55:48]);
        h = (h > 0) ? h - 1 : 0;
        r[55:48] = 8'(h);
        return r;
    endfunction

    function automatic int pick(input logic [1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic p, input logic [1:0] e,
                        input logic [1:0] o, input logic rdy);
        int we, wo;
        logic [1:0] xe, xo;
        @(negedge clk);
        rst = r; pol = p; re = e; ro = o; ri = rdy;
        #1;
        we = (r || p  || m_full[0]) ? -1 : pick(e, m_ptr[0]);
        wo = (r || !p || m_full[1]) ? -1 : pick(o, m_ptr[1]);
        xe = (we < 0) ? 2'b00 : 2'(1 << we);
        xo = (wo < 0) ? 2'b00 : 2'(1 << wo);
        obs_ge = bus1.gnt_even;
        obs_go = bus1.gnt_odd;
        chk("gnt_even", bus1.gnt_even, xe);
        chk("gnt_odd", bus1.gnt_odd, xo);
        chk("gnt_even_nohop", bus0.gnt_even, xe);
        chk("gnt_odd_nohop", bus0.gnt_odd, xo);
        @(posedge clk);
        if (r) begin
            m_full = '{0, 0};
            m_ptr  = '{0, 0};
            m_so = 1'b0; m_dout1 = '0; m_dout0 = '0;
        end else begin
            m_so = 1'b0;
            if (!p && m_full[1] && rdy) begin
                m_so = 1'b1; m_dout1 = m_buf1[1]; m_dout0 = m_buf0[1]; m_full[1] = 0;
            end
            if (p && m_full[0] && rdy) begin
                m_so = 1'b1; m_dout1 = m_buf1[0]; m_dout0 = m_buf0[0]; m_full[0] = 0;
            end
            if (we >= 0) begin
                m_buf1[0] = hop_model(de[we*DW +: DW]);
                m_buf0[0] = de[we*DW +: DW];
                m_full[0] = 1; m_ptr[0] = (we + 1) % N;
            end
            if (wo >= 0) begin
                m_buf1[1] = hop_model(dod[wo*DW +: DW]);
                m_buf0[1] = dod[wo*DW +: DW];
                m_full[1] = 1; m_ptr[1] = (wo + 1) % N;
            end
        end
        #1;
        obs_so = bus1.so; obs_dout1 = bus1.dout; obs_dout0 = bus0.dout;
        chk("so", bus1.so, m_so);
        chk("so_nohop", bus0.so, m_so);
        chk("dout", bus1.dout, m_dout1);
        chk("dout_nohop", bus0.dout, m_dout0);
    endtask

    initial begin
        rst = 1'b1; pol = 1'b0; re = '0; ro = '0; de = '0; dod = '0; ri = 1'b1;
        m_full = '{0, 0}; m_ptr = '{0, 0};
        m_buf1 = '{64'h0, 64'h0}; m_buf0 = '{64'h0, 64'h0};
        m_so = 1'b0; m_dout1 = '0; m_dout0 = '0;

        // reset held with requests pending
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i[0], 2'b11, 2'b00, 1'b1);
            chk("rst_gnt_even", obs_ge, 2'b00);
            chk("rst_so", obs_so, 1'b0);
            chk("rst_dout", obs_dout1, 64'h0);
        end

        // round robin on the even VC
        for (int i = 0; i < 8; i++) begin
            de = {$urandom, $urandom, $urandom, $urandom};
            step(1'b0, i[0], 2'b11, 2'b00, 1'b1);
            if (!i[0]) rr_seq[i/2] = obs_ge;
            chk("rr_so_pulse", obs_so, i[0]);
        end
        chk("rr_g0", rr_seq[0], 2'b01);
        chk("rr_g1", rr_seq[1], 2'b10);
        chk("rr_g2", rr_seq[2], 2'b01);
        chk("rr_g3", rr_seq[3], 2'b10);

        // hop field decrement, and saturation at zero
        dod[63:0] = 64'h0005_0000_0000_ABCD;
        step(1'b0, 1'b1, 2'b00, 2'b01, 1'b1);
        step(1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        chk("hop_so", obs_so, 1'b1);
        chk("hop_dec", obs_dout1, 64'h0004_0000_0000_ABCD);
        chk("hop_pass", obs_dout0, 64'h0005_0000_0000_ABCD);
        dod[63:0] = 64'h0000_0000_0000_1234;
        step(1'b0, 1'b1, 2'b00, 2'b01, 1'b1);
        step(1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        chk("hop_sat", obs_dout1, 64'h0000_0000_0000_1234);

        // backpressure with the even buffer full
        step(1'b0, 1'b0, 2'b11, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, ~i[0], 2'b11, 2'b00, 1'b0);
            chk("bp_no_gnt", obs_ge, 2'b00);
            chk("bp_no_so", obs_so, 1'b0);
        end
        step(1'b0, 1'b1, 2'b11, 2'b00, 1'b1);
        chk("bp_release_so", obs_so, 1'b1);
        step(1'b0, 1'b0, 2'b11, 2'b00, 1'b1);
        chk("bp_regrant", obs_ge, 2'b10);
        step(1'b0, 1'b1, 2'b00, 2'b00, 1'b1);

        // polarity held at 0: odd VC never granted
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 2'b11, 2'b11, 1'b1);
            chk("phase_no_odd", obs_go, 2'b00);
            chk("phase_no_so", obs_so, 1'b0);
        end
        step(1'b0, 1'b1, 2'b00, 2'b00, 1'b1);

        // reset with both buffers full
        de  = {$urandom, $urandom, $urandom, $urandom};
        dod = {$urandom, $urandom, $urandom, $urandom};
        step(1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
        step(1'b0, 1'b1, 2'b00, 2'b11, 1'b0);
        step(1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
        chk("midrst_so", obs_so, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, i[0], 2'b00, 2'b00, 1'b1);
            chk("midrst_no_stale", obs_so, 1'b0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            de  = {$urandom, $urandom, $urandom, $urandom};
            dod = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom),
                 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
